// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: load/MAC/accumulate/ReLU/output sequencer for one RepVGG conv layer.
// Define SEQ_PERF_CNT_EN to build the active-cycle counter behind perf_cycles.
module conv_seq_ctrl #(
    parameter int RD_CYC    = 2,
    parameter int KCOL      = 3,
    parameter int CHANNELS  = 32,
    parameter int OUT_BEATS = 7,
    parameter int COLS      = 560,
    parameter int IDX_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ctrl,
    output logic [31:0]      status,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] col_idx,
    output logic [IDX_W-1:0] chan_idx,
    output logic [31:0]      perf_cycles
);
    localparam int DW = RD_CYC > 1 ? $clog2(RD_CYC) : 1;
    localparam int KW = KCOL > 1 ? $clog2(KCOL) : 1;
    localparam int HW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int BW = OUT_BEATS > 1 ? $clog2(OUT_BEATS) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_READ, S_EN, S_ROVER, S_DISEN, S_ROVER2, S_MAC,
        S_PA, S_BA, S_CA, S_RELU, S_PAR, S_OUT
    } state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_dwell;
    logic [KW-1:0] r_kcol;
    logic [HW-1:0] r_chan;
    logic [BW-1:0] r_beat;
    logic [CW-1:0] r_col;
    logic          r_done;
    logic          w_start, w_abort, w_en, w_unused_ctrl;
    logic          w_dwell_last, w_kcol_last, w_chan_last, w_beat_last, w_col_last;

    assign w_start       = ctrl[0];
    assign w_abort       = ctrl[1];
    assign w_en          = ctrl[2];
    assign w_unused_ctrl = ^ctrl[31:3];
    assign w_dwell_last  = r_dwell == DW'(RD_CYC - 1);
    assign w_kcol_last   = r_kcol == KW'(KCOL - 1);
    assign w_chan_last   = r_chan == HW'(CHANNELS - 1);
    assign w_beat_last   = r_beat == BW'(OUT_BEATS - 1);
    assign w_col_last    = r_col == CW'(COLS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Abort overrides en; with en low nothing advances.
    always_comb begin
        w_next = r_state;
        if (w_abort) w_next = S_IDLE;
        else if (w_en)
            case (r_state)
                S_IDLE:   w_next = w_start ? S_READ : S_IDLE;
                S_READ:   w_next = S_EN;
                S_EN:     w_next = w_dwell_last ? S_ROVER : S_EN;
                S_ROVER:  w_next = w_dwell_last ? S_DISEN : S_ROVER;
                S_DISEN:  w_next = S_ROVER2;
                S_ROVER2: w_next = S_MAC;
                S_MAC:    w_next = S_PA;
                S_PA:     w_next = w_kcol_last ? S_BA : S_READ;
                S_BA:     w_next = S_CA;
                S_CA:     w_next = w_chan_last ? S_RELU : S_READ;
                S_RELU:   w_next = S_PAR;
                S_PAR:    w_next = S_OUT;
                S_OUT:    w_next = !w_beat_last ? S_OUT : (w_col_last ? S_IDLE : S_READ);
                default:  w_next = S_IDLE;
            endcase
    end

    always_comb begin
        status = 32'h0;
        case (r_state)
            S_READ:   status = 32'h3;
            S_EN:     status = 32'h33;
            S_ROVER:  status = 32'h31;
            S_DISEN:  status = 32'h11;
            S_ROVER2: status = 32'h10;
            S_MAC:    status = 32'hC;
            S_PA:     status = 32'hC0;
            S_BA:     status = 32'h100;
            S_CA:     status = 32'h200;
            S_RELU:   status = 32'h400;
            S_PAR:    status = 32'h800;
            S_OUT:    status = 32'h1000;
            default:  status = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_abort) begin
            r_dwell <= '0;
            r_kcol  <= '0;
            r_chan  <= '0;
            r_beat  <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_en && r_state == S_OUT && w_beat_last && w_col_last;
            if (w_en) begin
                if (r_state == S_EN || r_state == S_ROVER) r_dwell <= w_dwell_last ? '0 : r_dwell + 1'b1;
                if (r_state == S_PA) r_kcol <= w_kcol_last ? '0 : r_kcol + 1'b1;
                if (r_state == S_CA) r_chan <= w_chan_last ? '0 : r_chan + 1'b1;
                if (r_state == S_OUT) r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
                if (r_state == S_OUT && w_beat_last) r_col <= w_col_last ? '0 : r_col + 1'b1;
            end
        end
    end

    assign busy     = r_state != S_IDLE;
    assign done     = r_done;
    assign col_idx  = IDX_W'(r_col);
    assign chan_idx = IDX_W'(r_chan);

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_perf;
    // Survives abort and completion so the host can read the last run; restarts on a fresh start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_perf <= '0;
        else if (r_state == S_IDLE && w_next == S_READ) r_perf <= '0;
        else if (w_en && busy && r_perf != '1)       r_perf <= r_perf + 1'b1;
    end
    assign perf_cycles = r_perf;
`else
    assign perf_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: default-parameter DUT for the schedule and abort, small DUT for full layers.
module tb_conv_seq_ctrl;
    logic        clk = 1'b0, rst;
    logic [31:0] d_ctrl, s_ctrl, d_status, s_status, d_perf, s_perf;
    logic        d_busy, d_done, s_busy, s_done;
    logic [15:0] d_col, d_chan, s_col, s_chan;
    int          errors = 0, checks = 0, d_done_cnt = 0;

`ifdef SEQ_PERF_CNT_EN
    localparam int PERF_EXP = 74;
`else
    localparam int PERF_EXP = 0;
`endif
    localparam logic [31:0] PASS_PAT [9] = '{32'h3, 32'h33, 32'h33, 32'h31, 32'h31, 32'h11, 32'h10, 32'hC, 32'hC0};

    typedef struct { logic [31:0] ctrl; logic [31:0] status; logic [15:0] chan; } vec_t;
    vec_t vecs [30];
    vec_t sb [$];

    always #5 clk = ~clk;
    always @(negedge clk) if (d_done === 1'b1) d_done_cnt++;

    conv_seq_ctrl u_def (
        .clk(clk), .rst(rst), .ctrl(d_ctrl), .status(d_status), .busy(d_busy), .done(d_done),
        .col_idx(d_col), .chan_idx(d_chan), .perf_cycles(d_perf)
    );
    conv_seq_ctrl #(.RD_CYC(1), .KCOL(2), .CHANNELS(2), .OUT_BEATS(3), .COLS(2)) u_small (
        .clk(clk), .rst(rst), .ctrl(s_ctrl), .status(s_status), .busy(s_busy), .done(s_done),
        .col_idx(s_col), .chan_idx(s_chan), .perf_cycles(s_perf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one small layer from a start edge; optionally freezes en for 5 cycles in EN and in OUT.
    task automatic run_small(input bit gate, input bit hold, output int done_at);
        bit g_en = 0, g_out = 0;
        int t = 0;
        logic [31:0] st;
        logic [15:0] co, ch;
        done_at = -1;
        s_ctrl = 32'h5;
        step;
        s_ctrl = hold ? 32'h5 : 32'h4;
        while (t < 300 && done_at < 0) begin
            if (s_done === 1'b1) done_at = t;
            else if (gate && ((!g_en && s_status == 32'h33) || (!g_out && s_status == 32'h1000))) begin
                if (s_status == 32'h33) g_en = 1; else g_out = 1;
                st = s_status; co = s_col; ch = s_chan;
                s_ctrl = 32'h0;
                repeat (5) begin
                    step; t++;
                    chk("freeze status", s_status, st);
                    chk("freeze col", s_col, co);
                    chk("freeze chan", s_chan, ch);
                end
                s_ctrl = 32'h4;
            end else begin
                step; t++;
            end
        end
    endtask

    initial begin
        int da;
        vec_t e;
        for (int i = 0; i < 27; i++) vecs[i] = '{(i == 0) ? 32'h5 : 32'h4, PASS_PAT[i % 9], 16'd0};
        vecs[27] = '{32'h4, 32'h100, 16'd0};
        vecs[28] = '{32'h4, 32'h200, 16'd0};
        vecs[29] = '{32'h4, 32'h3, 16'd1};

        rst = 1'b1; d_ctrl = '0; s_ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst status", d_status, 0);
        chk("rst busy", d_busy, 0);
        chk("rst done", d_done, 0);
        chk("rst col", d_col, 0);
        chk("rst chan", d_chan, 0);
        chk("rst perf", d_perf, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            d_ctrl = vecs[i].ctrl;
            sb.push_back(vecs[i]);
            step;
            e = sb.pop_front();
            chk($sformatf("seq%0d status", i), d_status, e.status);
            chk($sformatf("seq%0d chan", i), d_chan, e.chan);
        end

        repeat (1060) step;
        chk("mac5 status", d_status, 32'hC);
        chk("mac5 col", d_col, 1);
        chk("mac5 chan", d_chan, 5);
        d_ctrl = 32'h6;
        step;
        chk("abort status", d_status, 0);
        chk("abort busy", d_busy, 0);
        chk("abort col", d_col, 0);
        chk("abort chan", d_chan, 0);
        chk("abort done", d_done, 0);
        d_ctrl = 32'h7;
        step;
        chk("abort over start", d_status, 0);
        d_ctrl = 32'h0;
        repeat (3) step;
        chk("no done after abort", d_done_cnt, 0);

        run_small(0, 0, da);
        chk("layer cycles", da, 74);
        chk("layer perf", s_perf, PERF_EXP);
        chk("layer idle busy", s_busy, 0);
        chk("layer idle status", s_status, 0);
        step;
        chk("done one cycle", s_done, 0);
        repeat (3) step;
        chk("perf holds", s_perf, PERF_EXP);
        chk("idle col", s_col, 0);

        run_small(1, 0, da);
        chk("gated layer cycles", da, 84);
        chk("gated perf", s_perf, PERF_EXP);
        step;

        run_small(0, 1, da);
        chk("held layer cycles", da, 74);
        step;
        chk("restart status", s_status, 32'h3);
        chk("restart col", s_col, 0);
        chk("restart busy", s_busy, 1);
        chk("restart perf", s_perf, 0);
        for (int k = 0; k < 200 && !(s_status == 32'h1000 && s_col == 16'd1); k++) step;
        chk("reach out col1", s_status, 32'h1000);
        #2 rst = 1'b1;
        #1;
        chk("arst status", s_status, 0);
        chk("arst busy", s_busy, 0);
        chk("arst done", s_done, 0);
        chk("arst col", s_col, 0);
        chk("arst chan", s_chan, 0);
        chk("arst perf", s_perf, 0);
        @(negedge clk) rst = 1'b0;
        s_ctrl = 32'h4;
        repeat (3) step;
        chk("post rst status", s_status, 0);
        chk("post rst busy", s_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
